// File: rtl/timer_a_capture_compare_pkg.sv
// Shared Timer_A constants (mode control, output modes, capture edge/input selects)
// and the capture-edge match helper.
package timer_a_capture_compare_pkg;

  typedef enum logic [1:0] {
    MC__STOP       = 2'd0,
    MC__UP         = 2'd1,
    MC__CONTINUOUS = 2'd2,
    MC__UPDOWN     = 2'd3
  } mc_t;

  typedef enum logic [2:0] {
    OUTMOD__OUTBIT  = 3'd0,
    OUTMOD__SET     = 3'd1,
    OUTMOD__TOG_RST = 3'd2,
    OUTMOD__SET_RST = 3'd3,
    OUTMOD__TOGGLE  = 3'd4,
    OUTMOD__RESET   = 3'd5,
    OUTMOD__TOG_SET = 3'd6,
    OUTMOD__RST_SET = 3'd7
  } outmod_t;

  typedef enum logic [1:0] {
    CM__NONE = 2'd0,
    CM__RISE = 2'd1,
    CM__FALL = 2'd2,
    CM__BOTH = 2'd3
  } cm_t;

  typedef enum logic [1:0] {
    CCIS__CCIA = 2'd0,
    CCIS__CCIB = 2'd1,
    CCIS__GND  = 2'd2,
    CCIS__VCC  = 2'd3
  } ccis_t;

  // CM bit 0 arms rising edges, bit 1 arms falling edges.
  function automatic logic cm_hit(input logic [1:0] cm, input logic rise, input logic fall);
    return (cm[0] & rise) | (cm[1] & fall);
  endfunction

endpackage

// File: rtl/timer_a_capture_compare_if.sv
// TAxCCTLn / TAxCCRn register-side bundle between the CPU register file and one channel.
interface timer_a_capture_compare_if #(parameter int WIDTH = 16);
  logic             CAP;
  logic [1:0]       CM;
  logic [1:0]       CCIS;
  logic             SCS;
  logic [2:0]       OUTMOD;
  logic             OUTbit;
  logic             CCIFG;
  logic             CCRwr;
  logic [WIDTH-1:0] CCRwdata;
  logic [WIDTH-1:0] CCR;
  logic             CCIFGset;
  logic             COVset;
  logic             SCCI;
  logic             CCI;

  modport master (
    output CAP, CM, CCIS, SCS, OUTMOD, OUTbit, CCIFG, CCRwr, CCRwdata,
    input  CCR, CCIFGset, COVset, SCCI, CCI
  );

  modport slave (
    input  CAP, CM, CCIS, SCS, OUTMOD, OUTbit, CCIFG, CCRwr, CCRwdata,
    output CCR, CCIFGset, COVset, SCCI, CCI
  );
endinterface

// File: rtl/timer_a_output_unit.sv
// OUTMOD decode and OUT flop. Full modes 0..7 only with TIMERA_OUTUNIT_EN defined;
// otherwise OUT simply registers OUTbit.
module timer_a_output_unit
  import timer_a_capture_compare_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mc,
  input  logic [2:0] outmod,
  input  logic       out_bit,
  input  logic       equ_n,
  input  logic       equ0,
  output logic       out
);

`ifdef TIMERA_OUTUNIT_EN
  logic e0, out_nxt;

  // Channel 0's own EQU is EQU0, so only the EQUn half of dual actions applies there.
  assign e0 = (CHANNEL != 0) && equ0;

  always_comb begin
    out_nxt = out;
    if (outmod == OUTMOD__OUTBIT) begin
      out_nxt = out_bit;
    end else if (mc != MC__STOP) begin
      case (outmod)
        OUTMOD__SET:     if (equ_n) out_nxt = 1'b1;
        OUTMOD__TOG_RST: if (e0) out_nxt = 1'b0; else if (equ_n) out_nxt = ~out;
        OUTMOD__SET_RST: if (e0) out_nxt = 1'b0; else if (equ_n) out_nxt = 1'b1;
        OUTMOD__TOGGLE:  if (equ_n) out_nxt = ~out;
        OUTMOD__RESET:   if (equ_n) out_nxt = 1'b0;
        OUTMOD__TOG_SET: if (e0) out_nxt = 1'b1; else if (equ_n) out_nxt = ~out;
        OUTMOD__RST_SET: if (e0) out_nxt = 1'b1; else if (equ_n) out_nxt = 1'b0;
        default:         out_nxt = out;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) out <= 1'b0;
    else     out <= out_nxt;
`else
  logic unused_ok;
  assign unused_ok = ^{mc, outmod, equ_n, equ0, 1'(CHANNEL)};

  always_ff @(posedge clk or posedge rst)
    if (rst) out <= 1'b0;
    else     out <= out_bit;
`endif

endmodule

// File: rtl/timer_a_capture_compare.sv
// One Timer_A capture/compare channel: input sync + edge detect, capture/compare,
// CCR register, and the output unit (full OUTMOD set with TIMERA_OUTUNIT_EN).
module timer_a_capture_compare
  import timer_a_capture_compare_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int WIDTH   = 16
) (
  input  logic                             TimerClock,
  input  logic                             wTACLR,
  input  logic [1:0]                       MC,
  input  logic [WIDTH-1:0]                 TAxR,
  input  logic                             EQU0,
  input  logic                             CCIA,
  input  logic                             CCIB,
  output logic                             EQU,
  output logic                             OUT,
  timer_a_capture_compare_if.slave         cctl
);

  logic             sel_in, sync1, cci_q, cci_prev, cap_pend;
  logic             rise, fall, cap_edge, cap_fire, cmp_hit;
  logic [WIDTH-1:0] ccr;
  logic             ccifg_set, cov_set, scci;

  always_comb begin
    sel_in = 1'b0;
    case (cctl.CCIS)
      CCIS__CCIA: sel_in = CCIA;
      CCIS__CCIB: sel_in = CCIB;
      CCIS__GND:  sel_in = 1'b0;
      default:    sel_in = 1'b1;
    endcase
  end

  assign rise     = cci_q & ~cci_prev;
  assign fall     = ~cci_q & cci_prev;
  assign cap_edge = cctl.CAP && cm_hit(cctl.CM, rise, fall);
  // With SCS the capture lands one TimerClock after the edge is seen.
  assign cap_fire = cctl.CAP && (cctl.SCS ? cap_pend : cap_edge);
  assign EQU      = (TAxR == ccr) && !cctl.CAP;
  assign cmp_hit  = EQU && (MC != MC__STOP);

  always_ff @(posedge TimerClock or posedge wTACLR) begin
    if (wTACLR) begin
      sync1     <= 1'b0;
      cci_q     <= 1'b0;
      cci_prev  <= 1'b0;
      cap_pend  <= 1'b0;
      ccr       <= '0;
      ccifg_set <= 1'b0;
      cov_set   <= 1'b0;
      scci      <= 1'b0;
    end else begin
      sync1     <= sel_in;
      cci_q     <= sync1;
      cci_prev  <= cci_q;
      cap_pend  <= cap_edge & cctl.SCS;
      if (cap_fire)        ccr <= TAxR;
      else if (cctl.CCRwr) ccr <= cctl.CCRwdata;
      ccifg_set <= cap_fire | cmp_hit;
      cov_set   <= cap_fire & cctl.CCIFG;
      if (cmp_hit) scci <= cci_q;
    end
  end

  assign cctl.CCR      = ccr;
  assign cctl.CCIFGset = ccifg_set;
  assign cctl.COVset   = cov_set;
  assign cctl.SCCI     = scci;
  assign cctl.CCI      = cci_q;

  timer_a_output_unit #(.CHANNEL(CHANNEL)) u_out (
    .clk     (TimerClock),
    .rst     (wTACLR),
    .mc      (MC),
    .outmod  (cctl.OUTMOD),
    .out_bit (cctl.OUTbit),
    .equ_n   (EQU),
    .equ0    (EQU0),
    .out     (OUT)
  );

endmodule

// File: tb/tb_timer_a_capture_compare.sv
// Directed bench for one Timer_A capture/compare channel (CHANNEL=1, WIDTH=16).
module tb_timer_a_capture_compare;

  logic        TimerClock = 1'b0;
  logic        wTACLR;
  logic [1:0]  MC;
  logic [15:0] TAxR;
  logic        EQU0, CCIA, CCIB;
  logic        EQU, OUT;
  int          n_chk  = 0;
  int          n_pass = 0;

  timer_a_capture_compare_if #(.WIDTH(16)) cctl ();

  timer_a_capture_compare #(.CHANNEL(1), .WIDTH(16)) dut (
    .TimerClock (TimerClock),
    .wTACLR     (wTACLR),
    .MC         (MC),
    .TAxR       (TAxR),
    .EQU0       (EQU0),
    .CCIA       (CCIA),
    .CCIB       (CCIB),
    .EQU        (EQU),
    .OUT        (OUT),
    .cctl       (cctl)
  );

  always #5 TimerClock = ~TimerClock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge TimerClock);
    #1;
  endtask

  task automatic wr_ccr(input logic [15:0] v);
    cctl.CCRwr = 1'b1; cctl.CCRwdata = v;
    tick();
    cctl.CCRwr = 1'b0;
  endtask

  initial begin
    wTACLR = 1'b1; MC = 2'd0; TAxR = '0; EQU0 = 1'b0; CCIA = 1'b0; CCIB = 1'b0;
    cctl.CAP = 1'b0; cctl.CM = 2'd0; cctl.CCIS = 2'd0; cctl.SCS = 1'b0;
    cctl.OUTMOD = 3'd0; cctl.OUTbit = 1'b0; cctl.CCIFG = 1'b0;
    cctl.CCRwr = 1'b0; cctl.CCRwdata = '0;
    tick(); tick();

    // Reset state; EQU is combinational and TAxR == CCR == 0
    chk("rst_ccr",   cctl.CCR, 16'h0);
    chk("rst_out",   16'(OUT), 16'h0);
    chk("rst_ifg",   16'(cctl.CCIFGset), 16'h0);
    chk("rst_cov",   16'(cctl.COVset), 16'h0);
    chk("rst_scci",  16'(cctl.SCCI), 16'h0);
    chk("rst_equ",   16'(EQU), 16'h1);
    wTACLR = 1'b0;
    tick();

    // Compare mode, CCR=5
    wr_ccr(16'd5);
    chk("wr_ccr", cctl.CCR, 16'd5);
    TAxR = 16'd5; #1;
    chk("equ_stop", 16'(EQU), 16'h1);
    tick();
    chk("ifg_stop", 16'(cctl.CCIFGset), 16'h0);
    MC = 2'd1; TAxR = 16'd4; #1;
    chk("equ_4", 16'(EQU), 16'h0);
    tick();
    chk("ifg_4", 16'(cctl.CCIFGset), 16'h0);
    TAxR = 16'd5; #1;
    chk("equ_5", 16'(EQU), 16'h1);
    tick();
    chk("ifg_5", 16'(cctl.CCIFGset), 16'h1);
    TAxR = 16'd6;
    tick();
    chk("ifg_6", 16'(cctl.CCIFGset), 16'h0);

    // Mode 0 follows OUTbit in either build
    cctl.OUTbit = 1'b1; tick();
    chk("out_bit1", 16'(OUT), 16'h1);
    cctl.OUTbit = 1'b0; tick();
    chk("out_bit0", 16'(OUT), 16'h0);

    // Capture on CCIA rise, SCS=0, in STOP
    MC = 2'd0; cctl.CAP = 1'b1; cctl.CM = 2'd1; TAxR = 16'h1234;
    tick(); tick(); tick();
    CCIA = 1'b1;
    tick(); tick();
    chk("cap1_cci",  16'(cctl.CCI), 16'h1);
    chk("cap1_pre",  cctl.CCR, 16'd5);
    tick();
    chk("cap1_ccr",  cctl.CCR, 16'h1234);
    chk("cap1_ifg",  16'(cctl.CCIFGset), 16'h1);
    chk("cap1_cov",  16'(cctl.COVset), 16'h0);
    tick();
    chk("cap1_ifg_off", 16'(cctl.CCIFGset), 16'h0);

    // Second capture (falling) with CCIFG still set -> overflow
    cctl.CM = 2'd2; cctl.CCIFG = 1'b1; TAxR = 16'h5678; CCIA = 1'b0;
    tick(); tick(); tick();
    chk("cap2_ccr", cctl.CCR, 16'h5678);
    chk("cap2_ifg", 16'(cctl.CCIFGset), 16'h1);
    chk("cap2_cov", 16'(cctl.COVset), 16'h1);
    cctl.CCIFG = 1'b0;

    // SCS=1, both edges: capture one cycle after detection
    cctl.CM = 2'd3; cctl.SCS = 1'b1; TAxR = 16'hABCD; CCIA = 1'b1;
    tick(); tick(); tick();
    chk("scs_wait_ccr", cctl.CCR, 16'h5678);
    chk("scs_wait_ifg", 16'(cctl.CCIFGset), 16'h0);
    tick();
    chk("scs_ccr", cctl.CCR, 16'hABCD);
    chk("scs_ifg", 16'(cctl.CCIFGset), 16'h1);

    // Reset while an SCS capture is pending drops it
    CCIA = 1'b0;
    tick(); tick(); tick();
    #2 wTACLR = 1'b1; #1;
    chk("clr_ccr", cctl.CCR, 16'h0);
    chk("clr_out", 16'(OUT), 16'h0);
    tick();
    wTACLR = 1'b0;
    tick(); tick();
    chk("clr_ccr_after", cctl.CCR, 16'h0);
    chk("clr_ifg_after", 16'(cctl.CCIFGset), 16'h0);

    // CPU write collides with capture: capture wins
    cctl.SCS = 1'b0; cctl.CM = 2'd1; TAxR = 16'h0F0F; CCIA = 1'b1;
    tick(); tick();
    cctl.CCRwr = 1'b1; cctl.CCRwdata = 16'h7777;
    tick();
    cctl.CCRwr = 1'b0;
    chk("wr_vs_cap", cctl.CCR, 16'h0F0F);

    cctl.CAP = 1'b0; cctl.CM = 2'd0; CCIA = 1'b0;
`ifdef TIMERA_OUTUNIT_EN
    // Mode 7 PWM: CCR0=10 (EQU0 driven here), CCR1=3; reset at 3, set at wrap
    wr_ccr(16'd3);
    cctl.OUTMOD = 3'd7; MC = 2'd1;
    for (int p = 0; p < 2; p++)
      for (int t = 0; t <= 10; t++) begin
        TAxR = 16'(t); EQU0 = (t == 10);
        tick();
        if (p == 1) chk($sformatf("pwm7_t%0d", t), 16'(OUT), (t >= 3 && t < 10) ? 16'h0 : 16'h1);
      end

    // CCR1 == CCR0: EQU0 set beats EQUn reset
    MC = 2'd0; cctl.OUTMOD = 3'd0; cctl.OUTbit = 1'b0; tick();
    wr_ccr(16'd10);
    cctl.OUTMOD = 3'd7; MC = 2'd1; TAxR = 16'd10; EQU0 = 1'b1;
    tick();
    chk("equ0_wins", 16'(OUT), 16'h1);

    // Mode 4 toggles on every CCR1 match
    MC = 2'd0; EQU0 = 1'b0;
    wr_ccr(16'd3);
    cctl.OUTMOD = 3'd4; MC = 2'd1;
    for (int p = 0; p < 2; p++)
      for (int t = 0; t <= 10; t++) begin
        TAxR = 16'(t); EQU0 = (t == 10);
        tick();
        if (t == 3) chk($sformatf("tog_p%0d", p), 16'(OUT), (p == 0) ? 16'h0 : 16'h1);
      end

    // STOP holds OUT even on a match
    MC = 2'd0; TAxR = 16'd3; EQU0 = 1'b0;
    tick();
    chk("stop_hold", 16'(OUT), 16'h1);
`else
    // Without the output unit OUTMOD is ignored
    cctl.OUTMOD = 3'd7; MC = 2'd1; cctl.OUTbit = 1'b1; TAxR = 16'd0;
    tick();
    chk("noou_bit1", 16'(OUT), 16'h1);
    cctl.OUTbit = 1'b0;
    tick();
    chk("noou_bit0", 16'(OUT), 16'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
